myrisc_mc: RTL and testbench
============================

MYRISC_MC -- requirements
Module: myrisc_mc

Interface
REQ-001 Parameter DATA_W, default 16: register, ALU and memory data width; SHALL be at least 16.
REQ-002 Parameter ADDR_W, default 16: PC and memory address width; SHALL be at most DATA_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mem_req  output  1  memory transaction request, registered.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  ADDR_W  word address; valid while mem_req=1.
REQ-008 mem_wdata  output  DATA_W  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  DATA_W  read data; sampled on the edge where mem_ack=1.
REQ-010 mem_ack  input  1  transaction complete.
REQ-011 halt  output  1  core halted.
REQ-012 retired  output  32  retired-instruction count (see Configuration).

Function
REQ-013 ISA: add, addi, nand, lui, sw, lw, beq and jalr; 16-bit encoding taken from mem_rdata[15:0]; ra=[12:10], rb=[9:7], rc=[2:0], simm=[6:0] sign-extended to DATA_W.
REQ-014 lui: rd = zero-extended {inst[9:0],6'b0}.
REQ-015 ALU results SHALL wrap modulo 2^DATA_W.
REQ-016 Addresses SHALL be the low ADDR_W bits of the computed value; PC increment and the branch target pc+1+simm SHALL wrap modulo 2^ADDR_W.
REQ-017 Register r0 SHALL read 0; writes to r0 are discarded.
REQ-018 The FSM SHALL have four states: FETCH, EXEC, MEM, HALT.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, latch IR and go to EXEC.
REQ-020 EXEC, add/addi/nand/lui/beq/jalr: write back, update pc, retire, go to FETCH.
REQ-021 EXEC, lw/sw: go to MEM with mem_addr=rb+simm and mem_wdata=ra.
REQ-022 EXEC, inst=16'hFFFF: go to HALT; pc SHALL NOT change.
REQ-023 MEM: hold mem_req and all request fields stable until mem_ack; on mem_ack, lw writes ra, pc=pc+1, retire, go to FETCH.
REQ-024 mem_ack SHALL be accepted in the first cycle mem_req=1; minimum latency is 2 cycles for ALU/branch/jalr and 3 cycles for lw/sw.
REQ-025 mem_req SHALL deassert for at least the cycle following an ack in EXEC.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 jalr with ra==rb: pc SHALL take the old rb value; ra SHALL get pc+1.
REQ-028 beq SHALL compare full DATA_W values.
REQ-029 HALT: halt=1 and mem_req=0 permanently until reset; it is a terminal state.

Reset
REQ-030 rst=1 SHALL immediately force: state=FETCH, pc=0, all gprs=0, IR=0, halt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retired=0.
REQ-031 rst asserted mid-transaction SHALL abandon the transaction; a late mem_ack SHALL be ignored.
REQ-032 After rst deasserts, the first edge SHALL begin a fetch from address 0.

Configuration
REQ-033 Macro MYRISC_RETIRE_CNT_EN.
- Defined: retired SHALL increment by 1 per retired instruction, wrap at 2^32, and not count the halt instruction.
- Undefined: retired SHALL be constant 0, with no counter logic.

Verification
REQ-034 Zero-wait memory, program addi r1,r0,5; addi r2,r1,-1; add r3,r1,r2; halt -> r3=9, halt=1 after 8 cycles, retired=3 (with macro).
REQ-035 Ack delayed 3 cycles on every request -> mem_req, mem_addr and mem_we stable throughout; lw r4,[r0+2] with mem[2]=16'hBEEF -> r4=16'hBEEF.
REQ-036 DATA_W=32, ADDR_W=8, pc=8'hFF with addi -> next fetch at 0; lui r1,0x3FF -> r1=32'h0000FFC0.
REQ-037 beq r1,r1,-1 -> refetches the same address; jalr r2,r2 with r2=16'h0040 at pc=16'h0010 -> pc=16'h0040, r2=16'h0011.
REQ-038 Assert rst during the MEM state of a pending sw -> mem_req=0 that cycle; no write is observed; a late ack is ignored; the next fetch is at address 0.

Source files
------------

// File: rtl/myrisc_mc_if.sv
// rtl/myrisc_mc_if.sv - memory bus interface between the myrisc_mc core and its memory
interface myrisc_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/myrisc_mc.sv
// rtl/myrisc_mc.sv - multi-cycle myrisc core; optional retire counter under MYRISC_RETIRE_CNT_EN
module myrisc_mc #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   myrisc_mc_if.master bus,
   output logic        halt,
   output logic [31:0] retired
);

   if (DATA_W < 16 || ADDR_W > DATA_W || ADDR_W < 1) begin : g_bad_param
      $error("myrisc_mc: need DATA_W >= 16 and 1 <= ADDR_W <= DATA_W");
   end

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [15:0]         r_ir;
   logic [DATA_W-1:0]   r_gpr [0:7];
   logic                r_halt;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;

   logic [2:0]          w_op;
   logic [2:0]          w_ra;
   logic [2:0]          w_rb;
   logic [2:0]          w_rc;
   logic [DATA_W-1:0]   w_simm;
   logic [DATA_W-1:0]   w_lui;
   logic [DATA_W-1:0]   w_va;
   logic [DATA_W-1:0]   w_vb;
   logic [DATA_W-1:0]   w_vc;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [ADDR_W-1:0]   w_br_tgt;
   logic [ADDR_W-1:0]   w_ea;
   logic [DATA_W-1:0]   w_link;
   logic                w_is_halt;
   logic                w_is_mem;
   logic                w_wb_en;
   logic [DATA_W-1:0]   w_wb_val;
   logic [ADDR_W-1:0]   w_next_pc;

   assign w_op      = r_ir[15:13];
   assign w_ra      = r_ir[12:10];
   assign w_rb      = r_ir[9:7];
   assign w_rc      = r_ir[2:0];
   assign w_simm    = {{(DATA_W-7){r_ir[6]}}, r_ir[6:0]};
   assign w_lui     = DATA_W'({r_ir[9:0], 6'b0});

   // r0 is never written and reset to zero, so a plain array read yields 0 for it
   assign w_va      = r_gpr[w_ra];
   assign w_vb      = r_gpr[w_rb];
   assign w_vc      = r_gpr[w_rc];

   // address arithmetic is done in ADDR_W bits so it wraps at the address width
   assign w_pc_inc  = r_pc + ADDR_W'(1);
   assign w_br_tgt  = w_pc_inc + w_simm[ADDR_W-1:0];
   assign w_ea      = w_vb[ADDR_W-1:0] + w_simm[ADDR_W-1:0];
   assign w_link    = DATA_W'(w_pc_inc);

   assign w_is_halt = (r_ir == 16'hFFFF);
   assign w_is_mem  = (w_op == OP_SW) || (w_op == OP_LW);

   // write-back value and next pc for instructions that complete in EXEC
   always_comb begin
      w_wb_en   = 1'b0;
      w_wb_val  = '0;
      w_next_pc = w_pc_inc;
      case (w_op)
         OP_ADD:  begin w_wb_en = 1'b1; w_wb_val = w_vb + w_vc;    end
         OP_ADDI: begin w_wb_en = 1'b1; w_wb_val = w_vb + w_simm;  end
         OP_NAND: begin w_wb_en = 1'b1; w_wb_val = ~(w_vb & w_vc); end
         OP_LUI:  begin w_wb_en = 1'b1; w_wb_val = w_lui;          end
         OP_BEQ:  begin
            w_next_pc = (w_va == w_vb) ? w_br_tgt : w_pc_inc;
         end
         OP_JALR: begin
            // target uses the pre-write rb, so ra==rb still jumps to the old value
            w_wb_en   = 1'b1;
            w_wb_val  = w_link;
            w_next_pc = w_vb[ADDR_W-1:0];
         end
         default: ;
      endcase
   end

   // control FSM: owns pc, IR, register file and every registered bus output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_FETCH;
         r_pc        <= '0;
         r_ir        <= '0;
         r_halt      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         for (int i = 0; i < 8; i++) r_gpr[i] <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!r_mem_req) begin
                  // only reached straight out of reset; later fetches are launched early
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_pc;
               end else if (bus.mem_ack) begin
                  r_ir      <= bus.mem_rdata[15:0];
                  r_mem_req <= 1'b0;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_is_halt) begin
                  r_halt  <= 1'b1;
                  r_state <= S_HALT;
               end else if (w_is_mem) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= (w_op == OP_SW);
                  r_mem_addr  <= w_ea;
                  r_mem_wdata <= w_va;
                  r_state     <= S_MEM;
               end else begin
                  if (w_wb_en && (w_ra != 3'd0)) r_gpr[w_ra] <= w_wb_val;
                  r_pc       <= w_next_pc;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_next_pc;
                  r_state    <= S_FETCH;
               end
            end
            S_MEM: begin
               if (r_mem_req && bus.mem_ack) begin
                  if (!r_mem_we && (w_ra != 3'd0)) r_gpr[w_ra] <= bus.mem_rdata;
                  r_pc       <= w_pc_inc;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= w_pc_inc;
                  r_state    <= S_FETCH;
               end
            end
            default: begin
               r_halt    <= 1'b1;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign halt          = r_halt;

`ifdef MYRISC_RETIRE_CNT_EN
   logic        w_retire;
   logic [31:0] r_retired;

   assign w_retire = ((r_state == S_EXEC) && !w_is_halt && !w_is_mem) ||
                     ((r_state == S_MEM) && r_mem_req && bus.mem_ack);

   // one count per completed instruction; the halt word never reaches a retire point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + 32'd1;
   end

   assign retired = r_retired;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_myrisc_mc.sv
// tb/tb_myrisc_mc.sv - randomized model-checked bench for myrisc_mc
module tb_myrisc_mc;

   localparam int OP_ADD = 0, OP_ADDI = 1, OP_NAND = 2, OP_LUI = 3;
   localparam int OP_SW = 4, OP_LW = 5, OP_BEQ = 6, OP_JALR = 7;

   typedef logic [64:0] tx_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, rst_b = 1'b1, sel = 1'b0;
   logic        halt_a, halt_b;
   logic [31:0] ret_a, ret_b;

   myrisc_mc_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
   myrisc_mc_if #(.DATA_W(32), .ADDR_W(8))  ifb ();

   myrisc_mc #(.DATA_W(16), .ADDR_W(16)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa), .halt(halt_a), .retired(ret_a));
   myrisc_mc #(.DATA_W(32), .ADDR_W(8)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb), .halt(halt_b), .retired(ret_b));

   logic        m_req, m_we, m_halt, m_rst, ack;
   logic [31:0] m_addr, m_wdata, m_ret, dmask, rdata;
   assign m_req   = sel ? ifb.mem_req : ifa.mem_req;
   assign m_we    = sel ? ifb.mem_we  : ifa.mem_we;
   assign m_addr  = sel ? 32'(ifb.mem_addr)  : 32'(ifa.mem_addr);
   assign m_wdata = sel ? ifb.mem_wdata      : 32'(ifa.mem_wdata);
   assign m_halt  = sel ? halt_b : halt_a;
   assign m_ret   = sel ? ret_b  : ret_a;
   assign m_rst   = sel ? rst_b  : rst_a;
   assign dmask   = sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;

   logic [31:0] img [0:1023];
   logic [31:0] mem [0:1023];
   logic [31:0] mm  [0:1023];
   tx_t         tr[$];
   tx_t         exq[$];
   bit          ex_halt;
   int          ex_ret;

   int  lat_fix = 0, lat_cur, cnt, unstable = 0;
   bit  rand_lat = 0, noise_en = 1, noise, late = 0, pend;
   logic        p_we;
   logic [31:0] p_addr, p_wdata;
   int  n_chk = 0, n_pass = 0;

   assign rdata         = mem[m_addr[9:0]];
   assign ack           = m_req ? (cnt >= lat_cur) : (noise | late);
   assign ifa.mem_ack   = ack;
   assign ifb.mem_ack   = ack;
   assign ifa.mem_rdata = rdata[15:0];
   assign ifb.mem_rdata = rdata;

   // memory responder: latency, stray acks, request stability and transaction trace
   always @(posedge clk) begin
      if (m_rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= img[i];
         cnt     <= 0;
         pend    <= 1'b0;
         lat_cur <= lat_fix;
         noise   <= 1'b0;
      end else begin
         noise <= noise_en && ($urandom_range(0, 1) == 1);
         if (pend && !(m_req && m_we == p_we && m_addr == p_addr && (!p_we || m_wdata == p_wdata)))
            unstable <= unstable + 1;
         pend    <= m_req && !ack;
         p_we    <= m_we;
         p_addr  <= m_addr;
         p_wdata <= m_wdata;
         if (m_req && ack) begin
            tr.push_back({m_we, m_addr, m_we ? (m_wdata & dmask) : (rdata & dmask)});
            if (m_we) mem[m_addr[9:0]] <= m_wdata & dmask;
            cnt <= 0;
            if (rand_lat) lat_cur <= $urandom_range(0, 3);
         end else if (m_req) cnt <= cnt + 1;
         else cnt <= 0;
      end
   end

   task automatic check_val(input string tag, input tx_t got, input tx_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] rrr(input int op, input int a, input int b, input int c);
      return {16'h0, op[2:0], a[2:0], b[2:0], 4'b0, c[2:0]};
   endfunction
   function automatic logic [31:0] rri(input int op, input int a, input int b, input int imm);
      return {16'h0, op[2:0], a[2:0], b[2:0], imm[6:0]};
   endfunction
   function automatic logic [31:0] luii(input int a, input int imm);
      return {16'h0, 3'd3, a[2:0], imm[9:0]};
   endfunction

   task automatic clear_img();
      for (int i = 0; i < 1024; i++) img[i] = 32'h0;
   endtask

   // architectural reference: instruction-by-instruction interpretation of the ISA
   task automatic model_run(input bit s, input int maxt);
      logic [31:0] r [0:7];
      logic [31:0] dm, am, pc, npc, v, ad, simm, res;
      logic [15:0] ins;
      int a, b, c;
      bit wr;
      dm = s ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      am = s ? 32'h0000_00FF : 32'h0000_FFFF;
      for (int i = 0; i < 1024; i++) mm[i] = img[i];
      for (int i = 0; i < 8; i++) r[i] = 0;
      pc = 0; exq.delete(); ex_halt = 0; ex_ret = 0;
      while (exq.size() < maxt) begin
         v = mm[pc[9:0]] & dm;
         exq.push_back({1'b0, pc, v});
         ins = v[15:0];
         if (ins == 16'hFFFF) begin ex_halt = 1; break; end
         a = int'(ins[12:10]); b = int'(ins[9:7]); c = int'(ins[2:0]);
         simm = {{25{ins[6]}}, ins[6:0]};
         npc = (pc + 1) & am;
         wr = 1; res = 0;
         case (int'(ins[15:13]))
            OP_ADD:  res = r[b] + r[c];
            OP_ADDI: res = r[b] + simm;
            OP_NAND: res = ~(r[b] & r[c]);
            OP_LUI:  res = {22'h0, ins[9:0]} << 6;
            OP_SW: begin
               wr = 0;
               ad = (r[b] + simm) & am;
               exq.push_back({1'b1, ad, r[a]});
               mm[ad[9:0]] = r[a];
            end
            OP_LW: begin
               ad = (r[b] + simm) & am;
               res = mm[ad[9:0]] & dm;
               exq.push_back({1'b0, ad, res});
            end
            OP_BEQ: begin
               wr = 0;
               if (r[a] == r[b]) npc = (pc + 1 + simm) & am;
            end
            default: begin
               res = npc;
               npc = r[b] & am;
            end
         endcase
         if (wr && a != 0) r[a] = res & dm;
         pc = npc;
         ex_ret++;
      end
   endtask

   task automatic run_test(input string tag, input bit s, input int maxt, input bit lt, output int hcyc);
      int cyc, start, u0, n0;
      bit done;
      tx_t got;
      model_run(s, maxt);
      rst_a = 1; rst_b = 1; sel = s;
      repeat (2) @(negedge clk);
      tr.delete();
      u0 = unstable;
      late = lt;
      if (s) rst_b = 0; else rst_a = 0;
      @(negedge clk);
      late = 0;
      cyc = 0; start = -1; hcyc = -1; done = 0;
      while (!done && cyc < 40 * maxt + 100) begin
         if (start < 0 && m_req) start = cyc;
         if (hcyc < 0 && m_halt) hcyc = cyc - start;
         if (tr.size() >= exq.size() && (!ex_halt || m_halt)) done = 1;
         else begin @(negedge clk); cyc++; end
      end
      check_val({tag, "_done"}, tx_t'(done), 65'd1);
      for (int i = 0; i < exq.size(); i++) begin
         got = (i < tr.size()) ? tr[i] : 'x;
         check_val($sformatf("%s_tx%0d", tag, i), got, exq[i]);
      end
      check_val({tag, "_stable"}, tx_t'(unstable - u0), 65'd0);
      if (ex_halt) begin
         n0 = tr.size();
         repeat (3) @(negedge clk);
         check_val({tag, "_ntx"}, tx_t'(tr.size()), tx_t'(exq.size()));
         check_val({tag, "_halt_tx"}, tx_t'(n0), tx_t'(tr.size()));
         check_val({tag, "_halt"}, tx_t'({m_halt, m_req}), 65'b10);
`ifdef MYRISC_RETIRE_CNT_EN
         check_val({tag, "_retired"}, tx_t'(m_ret), tx_t'(ex_ret));
`else
         check_val({tag, "_retired"}, tx_t'(m_ret), 65'd0);
`endif
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int h, k, w;
      tx_t got;
      clear_img();
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check_val($sformatf("rst%0d_req", s), tx_t'(m_req), 65'd0);
         check_val($sformatf("rst%0d_we", s), tx_t'(m_we), 65'd0);
         check_val($sformatf("rst%0d_addr", s), tx_t'(m_addr), 65'd0);
         check_val($sformatf("rst%0d_wdata", s), tx_t'(m_wdata), 65'd0);
         check_val($sformatf("rst%0d_halt", s), tx_t'(m_halt), 65'd0);
         check_val($sformatf("rst%0d_ret", s), tx_t'(m_ret), 65'd0);
      end

      clear_img();
      img[0] = rri(OP_ADDI, 1, 0, 5); img[1] = rri(OP_ADDI, 2, 1, -1);
      img[2] = rrr(OP_ADD, 3, 1, 2);  img[3] = 32'hFFFF;
      run_test("p034", 0, 50, 0, h);
      check_val("p034_halt_cycles", tx_t'(h), 65'd8);
      img[3] = rri(OP_SW, 3, 0, 30); img[4] = 32'hFFFF;
      run_test("p034s", 0, 50, 0, h);
      got = (tr.size() > 4) ? tr[4] : 'x;
      check_val("p034s_r3", got, {1'b1, 32'd30, 32'd9});

      clear_img();
      lat_fix = 3;
      img[0] = rri(OP_BEQ, 0, 0, 9); img[2] = 32'hBEEF;
      img[10] = rri(OP_LW, 4, 0, 2); img[11] = rri(OP_SW, 4, 0, 5); img[12] = 32'hFFFF;
      run_test("p035", 0, 50, 0, h);
      got = (tr.size() > 4) ? tr[4] : 'x;
      check_val("p035_r4", got, {1'b1, 32'd5, 32'h0000_BEEF});
      lat_fix = 0;

      clear_img();
      img[0] = rri(OP_ADDI, 1, 0, -1); img[1] = rrr(OP_JALR, 0, 1, 0);
      img[255] = rri(OP_ADDI, 2, 0, 1);
      run_test("p036w", 1, 8, 0, h);
      got = (tr.size() > 3) ? tx_t'({tr[2][63:32], tr[3][63:32]}) : 'x;
      check_val("p036_wrap", got, {33'd0, 32'h0000_00FF} << 32);
      clear_img();
      img[0] = luii(1, 10'h3FF); img[1] = rri(OP_SW, 1, 0, 10); img[2] = 32'hFFFF;
      run_test("p036l", 1, 20, 0, h);
      got = (tr.size() > 2) ? tr[2] : 'x;
      check_val("p036_lui", got, {1'b1, 32'd10, 32'h0000_FFC0});

      clear_img();
      img[0] = rri(OP_BEQ, 1, 1, -1);
      run_test("p037b", 0, 4, 0, h);
      got = (tr.size() > 1) ? tx_t'(tr[1][63:32]) : 'x;
      check_val("p037_refetch", got, 65'd0);
      clear_img();
      img[0] = luii(2, 1); img[1] = rri(OP_BEQ, 0, 0, 14);
      img[16] = rrr(OP_JALR, 2, 2, 0);
      img[64] = rri(OP_SW, 2, 0, 20); img[65] = 32'hFFFF;
      run_test("p037j", 0, 20, 0, h);
      got = (tr.size() > 4) ? tx_t'({tr[3][63:32], tr[4]}) : 'x;
      check_val("p037_jalr", got, {32'h40, 1'b1, 32'd20, 32'h11} & {65{1'b1}});

      clear_img();
      img[0] = rri(OP_ADDI, 1, 0, 9); img[1] = rri(OP_SW, 1, 0, 7);
      img[2] = 32'hFFFF; img[7] = 32'h1234;
      sel = 0; lat_fix = 4; rst_a = 1; rst_b = 1;
      repeat (2) @(negedge clk);
      tr.delete();
      rst_a = 0;
      k = 0;
      while (!(m_req && m_we) && k < 100) begin @(negedge clk); k++; end
      check_val("p038_in_mem", tx_t'(m_req && m_we), 65'd1);
      @(negedge clk);
      #2 rst_a = 1;
      #1;
      check_val("p038_req_drop", tx_t'({m_req, m_we}), 65'd0);
      w = 0;
      foreach (tr[i]) if (tr[i][64]) w++;
      check_val("p038_no_write", tx_t'(w), 65'd0);
      run_test("p038", 0, 20, 1, h);
      lat_fix = 0;

      rand_lat = 1;
      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < 1024; i++) begin
            img[i] = $urandom();
            if ($urandom_range(0, 19) == 0) img[i][15:0] = 16'hFFFF;
         end
         run_test($sformatf("rnd%0d", t), (t >= 12), 80, (t % 3 == 0), h);
      end

      rst_a = 1; rst_b = 1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
